lsu_ctrl: RTL and testbench

- Load/store control stage that sits directly upstream of the byte-addressed data memory.
- Accepts one CPU memory request at a time over a valid/ready handshake and translates the CPU address to a memory offset.
- Checks alignment and address range, then drives the memory's chip-select, read strobe, word/half/byte write strobes, address and write data.
- Captures the read data, sign- or zero-extends it, and returns the result over a valid/ready response handshake.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_extend.sv | 23 ++
 rtl/lsu_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared op encodings, FSM state type and size helper for the load/store unit
package lsu_pkg;

  localparam logic [2:0] LSU_LW  = 3'd0;
  localparam logic [2:0] LSU_LH  = 3'd1;
  localparam logic [2:0] LSU_LHU = 3'd2;
  localparam logic [2:0] LSU_LB  = 3'd3;
  localparam logic [2:0] LSU_LBU = 3'd4;
  localparam logic [2:0] LSU_SW  = 3'd5;
  localparam logic [2:0] LSU_SH  = 3'd6;
  localparam logic [2:0] LSU_SB  = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Access size in bytes for an op code.
  function automatic logic [2:0] lsu_size(input logic [2:0] op);
    case (op)
      LSU_LW, LSU_SW:          lsu_size = 3'd4;
      LSU_LH, LSU_LHU, LSU_SH: lsu_size = 3'd2;
      default:                 lsu_size = 3'd1;
    endcase
  endfunction

  // Stores occupy the top three op codes.
  function automatic logic lsu_is_store(input logic [2:0] op);
    lsu_is_store = (op >= LSU_SW);
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - combinational sign/zero extension of raw load data by op
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o
);

  // Select and extend the low bits of the raw word; stores yield zero.
  always_comb begin
    data_o = 32'h0;
    case (op_i)
      LSU_LW:  data_o = raw_i;
      LSU_LH:  data_o = {{16{raw_i[15]}}, raw_i[15:0]};
      LSU_LHU: data_o = {16'h0, raw_i[15:0]};
      LSU_LB:  data_o = {{24{raw_i[7]}}, raw_i[7:0]};
      LSU_LBU: data_o = {24'h0, raw_i[7:0]};
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store control FSM in front of the data memory; LSU_PERF_EN adds perf counters
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] DM_BASE  = 32'h1001_0000,
  parameter int          DM_BYTES = 1024,
  parameter int          AW       = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_adel,
  output logic          resp_ades,
  output logic          cs,
  output logic          DM_R,
  output logic          DM_W_W,
  output logic          DM_W_H,
  output logic          DM_W_B,
  output logic [AW-1:0] DM_addr,
  output logic [31:0]   DM_data_in,
  input  logic [31:0]   DM_data_out
`ifdef LSU_PERF_EN
  ,
  output logic [31:0]   perf_loads,
  output logic [31:0]   perf_stores,
  output logic [31:0]   perf_excs
`endif
);

  lsu_state_e    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          adel_q, adel_d;
  logic          ades_q, ades_d;
  logic          cs_q, cs_d;
  logic          dm_r_q, dm_r_d;
  logic          w_w_q, w_w_d;
  logic          w_h_q, w_h_d;
  logic          w_b_q, w_b_d;
  logic [AW-1:0] dm_addr_q, dm_addr_d;
  logic [31:0]   dm_wdata_q, dm_wdata_d;

  logic [31:0] offset;
  logic [2:0]  size;
  logic [32:0] end33;
  logic        misaligned;
  logic        out_of_range;
  logic        req_store;
  logic [31:0] load_ext;

  // Address decode of the incoming request; below-base addresses wrap to a huge offset.
  always_comb begin
    offset       = req_addr - DM_BASE;
    size         = lsu_size(req_op);
    req_store    = lsu_is_store(req_op);
    end33        = {1'b0, offset} + {30'h0, size};
    misaligned   = ((size == 3'd4) && (offset[1:0] != 2'b00)) ||
                   ((size == 3'd2) && offset[0]);
    out_of_range = (end33 > 33'(DM_BYTES));
  end

  lsu_extend u_extend (
    .op_i   (op_q),
    .raw_i  (DM_data_out),
    .data_o (load_ext)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= LSU_LW;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      adel_q       <= 1'b0;
      ades_q       <= 1'b0;
      cs_q         <= 1'b0;
      dm_r_q       <= 1'b0;
      w_w_q        <= 1'b0;
      w_h_q        <= 1'b0;
      w_b_q        <= 1'b0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      adel_q       <= adel_d;
      ades_q       <= ades_d;
      cs_q         <= cs_d;
      dm_r_q       <= dm_r_d;
      w_w_q        <= w_w_d;
      w_h_q        <= w_h_d;
      w_b_q        <= w_b_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
    end
  end

  // Next state; strobes default low so they are high only for the single ACCESS cycle.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    adel_d       = adel_q;
    ades_d       = ades_q;
    cs_d         = 1'b0;
    dm_r_d       = 1'b0;
    w_w_d        = 1'b0;
    w_h_d        = 1'b0;
    w_b_d        = 1'b0;
    dm_addr_d    = dm_addr_q;
    dm_wdata_d   = dm_wdata_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          op_d        = req_op;
          req_ready_d = 1'b0;
          if (misaligned || out_of_range) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
            adel_d       = !req_store;
            ades_d       = req_store;
          end else begin
            state_d    = ACCESS;
            adel_d     = 1'b0;
            ades_d     = 1'b0;
            cs_d       = 1'b1;
            dm_r_d     = !req_store;
            w_w_d      = req_store && (size == 3'd4);
            w_h_d      = req_store && (size == 3'd2);
            w_b_d      = req_store && (size == 3'd1);
            dm_addr_d  = offset[AW-1:0];
            dm_wdata_d = req_wdata;
          end
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_ext;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

`ifdef LSU_PERF_EN
  logic [31:0] perf_loads_q, perf_stores_q, perf_excs_q;

  // Count each accepted response by its kind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads_q  <= 32'h0;
      perf_stores_q <= 32'h0;
      perf_excs_q   <= 32'h0;
    end else if ((state_q == RESP) && resp_ready) begin
      if (adel_q || ades_q) begin
        perf_excs_q <= perf_excs_q + 32'd1;
      end else if (lsu_is_store(op_q)) begin
        perf_stores_q <= perf_stores_q + 32'd1;
      end else begin
        perf_loads_q <= perf_loads_q + 32'd1;
      end
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_excs   = perf_excs_q;
`endif

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_adel  = adel_q;
  assign resp_ades  = ades_q;
  assign cs         = cs_q;
  assign DM_R       = dm_r_q;
  assign DM_W_W     = w_w_q;
  assign DM_W_H     = w_h_q;
  assign DM_W_B     = w_b_q;
  assign DM_addr    = dm_addr_q;
  assign DM_data_in = dm_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - table-driven self-checking bench for lsu_ctrl with a byte memory model
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_adel;
  logic        resp_ades;
  logic        cs;
  logic        DM_R;
  logic        DM_W_W;
  logic        DM_W_H;
  logic        DM_W_B;
  logic [10:0] DM_addr;
  logic [31:0] DM_data_in;
  logic [31:0] DM_data_out;
`ifdef LSU_PERF_EN
  logic [31:0] perf_loads, perf_stores, perf_excs;
`endif

  int checks = 0;
  int failures = 0;

  lsu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_adel   (resp_adel),
    .resp_ades   (resp_ades),
    .cs          (cs),
    .DM_R        (DM_R),
    .DM_W_W      (DM_W_W),
    .DM_W_H      (DM_W_H),
    .DM_W_B      (DM_W_B),
    .DM_addr     (DM_addr),
    .DM_data_in  (DM_data_in),
    .DM_data_out (DM_data_out)
`ifdef LSU_PERF_EN
    ,
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores),
    .perf_excs   (perf_excs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];

  function automatic logic [7:0] rd_byte(input int a);
    if (a < 1024) return mem[a];
    return 8'h00;
  endfunction

  always_comb begin
    DM_data_out = {rd_byte(int'(DM_addr) + 3), rd_byte(int'(DM_addr) + 2),
                   rd_byte(int'(DM_addr) + 1), rd_byte(int'(DM_addr))};
  end

  always @(posedge clk) begin
    if (cs) begin
      if (DM_W_W || DM_W_H || DM_W_B) begin
        if (int'(DM_addr) < 1024) mem[DM_addr] <= DM_data_in[7:0];
      end
      if (DM_W_W || DM_W_H) begin
        if (int'(DM_addr) + 1 < 1024) mem[DM_addr + 11'd1] <= DM_data_in[15:8];
      end
      if (DM_W_W) begin
        if (int'(DM_addr) + 3 < 1024) begin
          mem[DM_addr + 11'd2] <= DM_data_in[23:16];
          mem[DM_addr + 11'd3] <= DM_data_in[31:24];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic [3:0]  stb;   // {R, W, H, B} seen during the transaction
    int          lat;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic adel, input logic ades, input logic [3:0] stb);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.adel = adel; v.ades = ades; v.stb = stb;
    v.lat = (adel || ades) ? 1 : 2;
    return v;
  endfunction

  vec_t vecs [19];

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int cs_cnt;
    logic [3:0] stb;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; cs_cnt = 0; stb = 4'h0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (cs) cs_cnt++;
      stb = stb | {DM_R, DM_W_W, DM_W_H, DM_W_B};
      if (resp_valid) break;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
    chk({tag, "_rdata"}, resp_rdata, v.rdata);
    chk({tag, "_adel"}, {31'h0, resp_adel}, {31'h0, v.adel});
    chk({tag, "_ades"}, {31'h0, resp_ades}, {31'h0, v.ades});
    chk({tag, "_cs_cycles"}, 32'(cs_cnt), (v.stb != 4'h0) ? 32'd1 : 32'd0);
    chk({tag, "_strobes"}, {28'h0, stb}, {28'h0, v.stb});
    @(negedge clk);
    chk({tag, "_resp_drop"}, {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0;
    req_wdata = 32'h0; resp_ready = 1'b1;

    vecs[0]  = mk(3'd5, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0, 4'b0100);
    vecs[1]  = mk(3'd0, 32'h1001_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 4'b1000);
    vecs[2]  = mk(3'd3, 32'h1001_0007, 32'h0,         32'hFFFF_FFDE, 1'b0, 1'b0, 4'b1000);
    vecs[3]  = mk(3'd4, 32'h1001_0007, 32'h0,         32'h0000_00DE, 1'b0, 1'b0, 4'b1000);
    vecs[4]  = mk(3'd1, 32'h1001_0006, 32'h0,         32'hFFFF_DEAD, 1'b0, 1'b0, 4'b1000);
    vecs[5]  = mk(3'd2, 32'h1001_0006, 32'h0,         32'h0000_DEAD, 1'b0, 1'b0, 4'b1000);
    vecs[6]  = mk(3'd7, 32'h1001_0005, 32'h0000_0012, 32'h0,         1'b0, 1'b0, 4'b0001);
    vecs[7]  = mk(3'd0, 32'h1001_0004, 32'h0,         32'hDEAD_12EF, 1'b0, 1'b0, 4'b1000);
    vecs[8]  = mk(3'd0, 32'h1001_0002, 32'h0,         32'h0,         1'b1, 1'b0, 4'b0000);
    vecs[9]  = mk(3'd6, 32'h1001_03FF, 32'h1234_5678, 32'h0,         1'b0, 1'b1, 4'b0000);
    vecs[10] = mk(3'd5, 32'h1001_03FC, 32'h0123_4567, 32'h0,         1'b0, 1'b0, 4'b0100);
    vecs[11] = mk(3'd0, 32'h1001_03FC, 32'h0,         32'h0123_4567, 1'b0, 1'b0, 4'b1000);
    vecs[12] = mk(3'd5, 32'h1001_0400, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 4'b0000);
    vecs[13] = mk(3'd0, 32'h1000_FFFC, 32'h0,         32'h0,         1'b1, 1'b0, 4'b0000);
    vecs[14] = mk(3'd6, 32'h1001_0002, 32'hCAFE_8001, 32'h0,         1'b0, 1'b0, 4'b0010);
    vecs[15] = mk(3'd1, 32'h1001_0002, 32'h0,         32'hFFFF_8001, 1'b0, 1'b0, 4'b1000);
    vecs[16] = mk(3'd2, 32'h1001_0003, 32'h0,         32'h0,         1'b1, 1'b0, 4'b0000);
    vecs[17] = mk(3'd3, 32'h1001_03FF, 32'h0,         32'h0000_0001, 1'b0, 1'b0, 4'b1000);
    vecs[18] = mk(3'd1, 32'h1001_03FE, 32'h0,         32'h0000_0123, 1'b0, 1'b0, 4'b1000);

    // Reset state
    #12;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_strobes", {27'h0, cs, DM_R, DM_W_W, DM_W_H, DM_W_B}, 32'h0);
    chk("rst_addr_data", {21'h0, DM_addr} | DM_data_in | resp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

    // Back-pressure: response held with resp_ready low, new request refused
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h1001_0004; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_addr = 32'h1001_0008;
    begin
      int w;
      w = 0;
      while (!resp_valid && w < 8) begin @(negedge clk); w++; end
      chk("hold_reached_resp", {31'h0, resp_valid}, 32'h1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", k), {31'h0, resp_valid}, 32'h1);
      chk($sformatf("hold%0d_rdata", k), resp_rdata, 32'hDEAD_12EF);
      chk($sformatf("hold%0d_req_ready", k), {31'h0, req_ready, cs}, 32'h0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", {30'h0, resp_valid, req_ready}, 32'h1);

    // Asynchronous reset in the middle of a store ACCESS cycle
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h1001_0008; req_wdata = 32'h55AA_55AA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("mid_access_cs", {30'h0, cs, DM_W_W}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_strobes", {27'h0, cs, DM_R, DM_W_W, DM_W_H, DM_W_B}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {30'h0, req_ready, resp_valid}, 32'h2);

    run_vec(mk(3'd4, 32'h1001_0005, 32'h0, 32'h0000_0012, 1'b0, 1'b0, 4'b1000), 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
